// File: rtl/rifl_tx_pkg.sv
// Shared TX helpers: keep-word counting and counter sizing, used by the gearbox and frame builder.
package rifl_tx_pkg;

  localparam int unsigned MaxRatio = 64;

  typedef logic [$clog2(MaxRatio + 1) - 1:0] word_cnt_t;

  // Width of a counter that must hold the values 0..ratio inclusive.
  function automatic int unsigned word_cnt_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic word_cnt_t popcount(input logic [MaxRatio-1:0] vec);
    word_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < int'(MaxRatio); i++) begin
      cnt = cnt + word_cnt_t'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tx_dwidth_gearbox.sv
// TX downsizing gearbox: splits each wide beat into RATIO narrow words, MSB word first,
// with valid/ready on both sides and per-word keep.
module tx_dwidth_gearbox
  import rifl_tx_pkg::*;
#(
  parameter int unsigned DWIDTH_IN  = 256,
  parameter int unsigned DWIDTH_OUT = 64,
  localparam int unsigned RATIO     = DWIDTH_IN / DWIDTH_OUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DWIDTH_IN-1:0]  s_tdata,
  input  logic [RATIO-1:0]      s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DWIDTH_OUT-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tsof,
  output logic                  m_tlast,
  output logic                  keep_err
);

  localparam int unsigned CntW = word_cnt_width(RATIO);

  if (DWIDTH_IN % DWIDTH_OUT != 0) begin : g_bad_ratio
    $error("tx_dwidth_gearbox: DWIDTH_IN must be a multiple of DWIDTH_OUT");
  end
  if (RATIO > MaxRatio) begin : g_bad_max
    $error("tx_dwidth_gearbox: RATIO exceeds rifl_tx_pkg::MaxRatio");
  end

  logic [DWIDTH_IN-1:0] data_q, data_d;
  logic [CntW-1:0]      rem_q, rem_d;
  logic                 last_q, last_d;
  logic                 first_q, first_d;
  logic                 keep_err_q, keep_err_d;

  word_cnt_t keep_cnt;
  logic      keep_ok;
  logic      accept;
  logic      word_hs;

  // A kept-word pattern is legal only as a solid run of ones starting at the MSB.
  always_comb begin
    keep_cnt = popcount(MaxRatio'(s_tkeep));
    keep_ok  = 1'b1;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (s_tkeep[i] != (i >= int'(RATIO) - int'(keep_cnt))) begin
        keep_ok = 1'b0;
      end
    end
  end

  // Final word handshaking frees the register in the same cycle, so reload has no bubble.
  assign s_tready = (rem_q == '0) || ((rem_q == CntW'(1)) && m_tready);
  assign accept   = s_tvalid && s_tready;
  assign word_hs  = m_tvalid && m_tready;

  always_comb begin
    data_d     = data_q;
    rem_d      = rem_q;
    last_d     = last_q;
    first_d    = first_q;
    keep_err_d = 1'b0;
    if (accept) begin
      data_d     = s_tdata;
      rem_d      = CntW'(keep_cnt);
      last_d     = s_tlast;
      first_d    = 1'b1;
      keep_err_d = (keep_cnt == '0) || !keep_ok;
    end else if (word_hs) begin
      data_d  = data_q << DWIDTH_OUT;
      rem_d   = rem_q - CntW'(1);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      rem_q      <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b0;
      keep_err_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      rem_q      <= rem_d;
      last_q     <= last_d;
      first_q    <= first_d;
      keep_err_q <= keep_err_d;
    end
  end

  assign m_tvalid = (rem_q != '0);
  assign m_tdata  = data_q[DWIDTH_IN-1 -: DWIDTH_OUT];
  assign m_tsof   = first_q;
  assign m_tlast  = last_q && (rem_q == CntW'(1));
  assign keep_err = keep_err_q;

endmodule

// File: tb/tb_tx_dwidth_gearbox.sv
// Bench for tx_dwidth_gearbox: directed scenarios then random traffic against a word-queue model.
module tb_tx_dwidth_gearbox;

  localparam int unsigned DIN   = 256;
  localparam int unsigned DOUT  = 64;
  localparam int unsigned RATIO = DIN / DOUT;

  typedef struct packed {
    logic [DOUT-1:0] data;
    logic            sof;
    logic            last;
  } word_t;

  logic             clk;
  logic             rst_n;
  logic [DIN-1:0]   s_tdata;
  logic [RATIO-1:0] s_tkeep;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [DOUT-1:0]  m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tsof;
  logic             m_tlast;
  logic             keep_err;

  tx_dwidth_gearbox #(
    .DWIDTH_IN (DIN),
    .DWIDTH_OUT(DOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tsof  (m_tsof),
    .m_tlast (m_tlast),
    .keep_err(keep_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  word_t exp_q[$];
  logic  err_pend    = 1'b0;
  int    mode        = 0;  // 0: ready always, 1: pattern 1,0,0,1, 2: random
  int    tog_idx     = 0;

  task automatic chk(input string tag, input logic [DOUT-1:0] got, input logic [DOUT-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [DIN-1:0] rand_beat();
    logic [DIN-1:0] b;
    for (int i = 0; i < int'(DIN / 32); i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One clock: drive at posedge+1, check and update the model at negedge.
  task automatic cycle(input logic v, input logic [DIN-1:0] d, input logic [RATIO-1:0] k,
                       input logic l, output logic acc);
    logic exp_rdy;
    logic bad;
    logic seen_zero;
    int   n;
    logic [3:0] pat;
    pat      = 4'b1001;
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    case (mode)
      0:       m_tready = 1'b1;
      1:       begin m_tready = pat[3 - (tog_idx % 4)]; tog_idx++; end
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && m_tready);
    chk("m_tvalid", DOUT'(m_tvalid), DOUT'(exp_q.size() != 0));
    chk("s_tready", DOUT'(s_tready), DOUT'(exp_rdy));
    chk("keep_err", DOUT'(keep_err), DOUT'(err_pend));
    if (exp_q.size() != 0) begin
      chk("m_tdata", m_tdata, exp_q[0].data);
      chk("m_tsof", DOUT'(m_tsof), DOUT'(exp_q[0].sof));
      chk("m_tlast", DOUT'(m_tlast), DOUT'(exp_q[0].last));
      if (m_tready) void'(exp_q.pop_front());
    end
    acc      = v && exp_rdy;
    err_pend = 1'b0;
    if (acc) begin
      n         = 0;
      seen_zero = 1'b0;
      bad       = 1'b0;
      for (int i = RATIO - 1; i >= 0; i--) begin
        if (k[i]) begin
          n++;
          if (seen_zero) bad = 1'b1;
        end else begin
          seen_zero = 1'b1;
        end
      end
      if (n == 0) bad = 1'b1;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back('{data: d[DIN-1-j*DOUT -: DOUT], sof: (j == 0),
                          last: l && (j == n - 1)});
      end
      err_pend = bad;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DIN-1:0] d, input logic [RATIO-1:0] k, input logic l);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 64) begin
      cycle(1'b1, d, k, l, acc);
      t++;
    end
    vectors++;
    assert (acc) else begin
      miscompares++;
      $error("FAIL accept_timeout: observed %0d expected 1", acc);
    end
  endtask

  task automatic drain();
    logic acc;
    int   t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      cycle(1'b0, '0, '0, 1'b0, acc);
      t++;
    end
    cycle(1'b0, '0, '0, 1'b0, acc);
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain_timeout: observed %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [DIN-1:0]   beat;
    logic [RATIO-1:0] keep;
    logic             acc;

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_tvalid", DOUT'(m_tvalid), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_m_tsof", DOUT'(m_tsof), '0);
    chk("rst_m_tlast", DOUT'(m_tlast), '0);
    chk("rst_keep_err", DOUT'(keep_err), '0);
    chk("rst_s_tready", DOUT'(s_tready), DOUT'(1));
    @(posedge clk);
    #1;

    // Full beat A,B,C,D
    beat = {64'hAAAA_AAAA_0000_0001, 64'hBBBB_BBBB_0000_0002,
            64'hCCCC_CCCC_0000_0003, 64'hDDDD_DDDD_0000_0004};
    send_beat(beat, 4'hF, 1'b0);
    drain();

    // Three back-to-back full beats
    for (int b = 0; b < 3; b++) send_beat(rand_beat(), 4'hF, b == 2);
    drain();

    // Partial last beat
    send_beat(rand_beat(), 4'hC, 1'b1);
    drain();

    // Back-pressure pattern
    mode = 1;
    for (int b = 0; b < 3; b++) send_beat(rand_beat(), 4'hF, b == 2);
    drain();
    mode = 0;

    // Keep errors
    send_beat(rand_beat(), 4'h0, 1'b0);
    drain();
    send_beat(rand_beat(), 4'hA, 1'b1);
    drain();

    // Reset while word B is presented
    send_beat(beat, 4'hF, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", DOUT'(m_tvalid), '0);
    chk("arst_m_tsof", DOUT'(m_tsof), '0);
    chk("arst_m_tdata", m_tdata, '0);
    chk("arst_s_tready", DOUT'(s_tready), DOUT'(1));
    exp_q.delete();
    err_pend = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_beat(rand_beat(), 4'hF, 1'b1);
    drain();

    // Random traffic
    mode = 2;
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, '0, 1'b0, acc);
      if ($urandom_range(0, 9) == 0) keep = RATIO'($urandom);
      else keep = RATIO'(~((1 << (RATIO - $urandom_range(1, RATIO))) - 1));
      send_beat(rand_beat(), keep, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_dwidth_gearbox.md
# tx_dwidth_gearbox

Parametrised TX downsizing gearbox that splits each wide input beat into `RATIO = DWIDTH_IN/DWIDTH_OUT` narrow output words, MSB word first. It has full valid/ready back-pressure on both sides and per-word keep, so a partial final beat emits only its valid words. It sits between the TX frame builder and the lane serialiser. It is the handshaked successor to the fixed-cadence, counter-driven width converter.

## Interface
- `DWIDTH_IN`, 256: input beat width; must be an integer multiple of `DWIDTH_OUT` (elaboration `$error` otherwise).
- `DWIDTH_OUT`, 64: output word width.
- `RATIO`, derived localparam `DWIDTH_IN/DWIDTH_OUT`.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_tdata`  in  DWIDTH_IN  input beat; word k occupies bits `[DWIDTH_IN-1-k*DWIDTH_OUT -: DWIDTH_OUT]`.
- `s_tkeep`  in  RATIO  per-word valid; bit `RATIO-1` = word 0; must be contiguous from MSB.
- `s_tlast`  in  1  beat ends a frame.
- `s_tvalid`  in  1  beat valid.
- `s_tready`  out  1  gearbox accepts beat.
- `m_tdata`  out  DWIDTH_OUT  output word.
- `m_tvalid`  out  1  word valid.
- `m_tready`  in  1  downstream accepts word.
- `m_tsof`  out  1  word is word 0 of its input beat.
- `m_tlast`  out  1  final kept word of a `s_tlast` beat.
- `keep_err`  out  1  one-cycle pulse: beat with `s_tkeep == 0` or non-contiguous keep accepted.

## Operation
- Holding register `data_q` (DWIDTH_IN), remaining-word counter `rem_q` (`$clog2(RATIO+1)` bits), flag `last_q`, flag `first_q`.
- States: `EMPTY` (`rem_q == 0`) and `BUSY` (`rem_q > 0`).
- `s_tready = (rem_q == 0) || (rem_q == 1 && m_tready)`. This gives a zero-bubble reload on the final word.
- On accept: `data_q <= s_tdata`, `rem_q <= popcount(s_tkeep)`, `last_q <= s_tlast`, `first_q <= 1`.
- Outputs:
  - `m_tvalid = (rem_q != 0)`.
  - `m_tdata = data_q[DWIDTH_IN-1 -: DWIDTH_OUT]`.
  - `m_tsof = first_q`.
  - `m_tlast = last_q && rem_q == 1`.
- On word handshake without reload: `data_q <= data_q << DWIDTH_OUT`, `rem_q <= rem_q - 1`, `first_q <= 0`.
- Simultaneous final-word handshake and new accept: the reload wins, and the old final word is emitted that cycle.
- `s_tkeep == 0`: the beat is consumed, nothing is emitted, `rem_q` stays 0, and `keep_err` pulses. If the beat also carries `s_tlast`, the frame end is lost; upstream must never send this.
- Non-contiguous keep: word count is `popcount`, words are taken MSB-first, and `keep_err` pulses.
- `RATIO == 1`: same logic applies. The block is a registered one-stage buffer with `m_tsof` always 1.
- `m_tdata`, `m_tsof` and `m_tlast` are held stable while `m_tvalid && !m_tready` (AXI-S rule).

## Timing
- Reset values: `data_q = 0`, `rem_q = 0`, `last_q = 0`, `first_q = 0`, `keep_err = 0`. Therefore `m_tvalid = 0`, `m_tdata = 0`, `m_tsof = 0`, `m_tlast = 0`, and `s_tready = 1` after reset.
- Reset asserted mid-beat discards the remaining words. There is no partial-frame recovery.
- Latency is 1 cycle: a beat accepted at edge n presents word 0 after edge n.
- Throughput is 1 word/cycle sustained when `m_tready = 1`. A full-keep stream accepts 1 beat every RATIO cycles.
- `s_tready` depends combinationally on `m_tready`; this is the only comb path. All outputs other than `s_tready` are registered.

## Structure
- Shared package `rifl_tx_pkg` holds `function automatic popcount` and the `word_cnt_t` width helper, reused by the frame builder.
- No sub-module. The counter and shifter are local.

## Test plan
- Full beat, ratio 4 (256→64): `s_tdata = {A,B,C,D}`, keep `4'hF`, `m_tready = 1` → A,B,C,D on 4 consecutive cycles; `m_tsof` only on A; `s_tready` high on the D cycle.
- Back-to-back beats: 3 full beats with `s_tvalid` held high → 12 contiguous words, no bubble, `m_tsof` every 4th word.
- Partial last beat: keep `4'hC`, `s_tlast = 1` → exactly 2 words; `m_tlast` on the 2nd; 3rd cycle `m_tvalid = 0`.
- Back-pressure: `m_tready` toggles 1,0,0,1,… → words are not skipped or duplicated, data stays stable while stalled, and `s_tready` stays low until the final word handshakes.
- Errors: keep `4'h0` → no output, `keep_err` pulses 1 cycle. Keep `4'hA` → 2 words emitted, `keep_err` pulses.
- Reset mid-beat: `rst_n` low after word B → `m_tvalid` drops immediately (asynchronously); after release `s_tready = 1` and the next beat starts clean with `m_tsof = 1`.
